crash_course_cpu_run_controller: RTL

- Parametrised run-control unit: the next generation of the CPU top's system-enable/halt logic.
- Adds single-step, a breakpoint array, an external debugger halt, a watchdog, and cycle and halt-cause reporting.
- Drives the system_enabled qualifier consumed by the program counter, dataloop and data memory.
- Sits beside the instruction decoder and observes program_counter and halt_enable.

---
 rtl/crash_course_cpu_run_control_pkg.sv | 26 ++
 rtl/crash_course_cpu_breakpoint_match.sv | 32 +++
 rtl/crash_course_cpu_run_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/crash_course_cpu_run_control_pkg.sv
// Shared types for the CPU run controller: run state, halt cause and the
// breakpoint index width helper.
package crash_course_cpu_run_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE       = 3'd0,
        CAUSE_HALT_INSTR = 3'd1,
        CAUSE_BREAKPOINT = 3'd2,
        CAUSE_EXTERNAL   = 3'd3,
        CAUSE_WATCHDOG   = 3'd4,
        CAUSE_STEP_DONE  = 3'd5
    } halt_cause_t;

    // A single comparator still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/crash_course_cpu_breakpoint_match.sv
// Breakpoint comparator array: any-hit flag plus lowest matching index.
module crash_course_cpu_breakpoint_match
    import crash_course_cpu_run_control_pkg::*;
#(
    parameter int PC_WIDTH = 8,
    parameter int BP_COUNT = 4,
    localparam int IDX_W   = idx_width(BP_COUNT)
) (
    input  logic [PC_WIDTH-1:0]                program_counter,
    input  logic [BP_COUNT-1:0]                bp_enable,
    input  logic [BP_COUNT-1:0][PC_WIDTH-1:0]  bp_address,
    output logic                               hit,
    output logic [IDX_W-1:0]                   hit_index
);

    logic [BP_COUNT-1:0] match;

    for (genvar i = 0; i < BP_COUNT; i++) begin : g_cmp
        assign match[i] = bp_enable[i] && (bp_address[i] == program_counter);
    end

    assign hit = |match;

    // Scan downward so the lowest matching index wins.
    always_comb begin
        hit_index = '0;
        for (int i = BP_COUNT - 1; i >= 0; i--) begin
            if (match[i]) hit_index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/crash_course_cpu_run_controller.sv
// CPU run controller: run/step/halt sequencing with breakpoints, debugger
// halt, watchdog and cycle/halt-cause reporting.
module crash_course_cpu_run_controller
    import crash_course_cpu_run_control_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int BP_COUNT    = 4,
    parameter int CYCLE_WIDTH = 16,
    localparam int IDX_W      = idx_width(BP_COUNT)
) (
    input  logic                               clk,
    input  logic                               clk_en,
    input  logic                               sync_rst,
    input  logic                               system_start,
    input  logic                               step_request,
    input  logic                               halt_request,
    input  logic                               abort_request,
    input  logic                               halt_enable,
    input  logic [PC_WIDTH-1:0]                program_counter,
    input  logic [BP_COUNT-1:0]                bp_enable,
    input  logic [BP_COUNT-1:0][PC_WIDTH-1:0]  bp_address,
    input  logic [CYCLE_WIDTH-1:0]             watchdog_limit,
    output logic                               system_enabled,
    output logic                               system_idle,
    output logic                               halted,
    output logic [2:0]                         halt_cause,
    output logic [IDX_W-1:0]                   bp_hit_index,
    output logic [CYCLE_WIDTH-1:0]             cycle_count
);

    localparam logic [CYCLE_WIDTH:0] WD_ONE = 1;

    run_state_t              state, next_state;
    halt_cause_t             cause, next_cause;
    logic                    skip_bp, raw_hit, bp_hit, wd_expire;
    logic                    enter_exec, clear_cycles, latch_bp;
    logic [IDX_W-1:0]        raw_idx;
    logic [CYCLE_WIDTH-1:0]  wd_count;

    crash_course_cpu_breakpoint_match #(
        .PC_WIDTH (PC_WIDTH),
        .BP_COUNT (BP_COUNT)
    ) u_bp_match (
        .program_counter (program_counter),
        .bp_enable       (bp_enable),
        .bp_address      (bp_address),
        .hit             (raw_hit),
        .hit_index       (raw_idx)
    );

    // skip_bp lets a resume execute the instruction that tripped the breakpoint.
    assign bp_hit    = raw_hit && !skip_bp;
    assign wd_expire = (watchdog_limit != '0) &&
                       (({1'b0, wd_count} + WD_ONE) == {1'b0, watchdog_limit});

    always_ff @(posedge clk) begin
        if (sync_rst)    state <= ST_IDLE;
        else if (clk_en) state <= next_state;
    end

    always_comb begin
        next_state   = state;
        next_cause   = cause;
        enter_exec   = 1'b0;
        clear_cycles = 1'b0;
        latch_bp     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!halt_request && system_start) begin
                    next_state   = ST_RUN;
                    enter_exec   = 1'b1;
                    clear_cycles = 1'b1;
                end else if (!halt_request && step_request) begin
                    next_state   = ST_STEP;
                    enter_exec   = 1'b1;
                    clear_cycles = 1'b1;
                end
            end
            ST_RUN: begin
                if (bp_hit) begin
                    next_state = ST_HALTED;
                    next_cause = CAUSE_BREAKPOINT;
                    latch_bp   = 1'b1;
                end else if (halt_enable) begin
                    next_state = ST_HALTED;
                    next_cause = CAUSE_HALT_INSTR;
                end else if (halt_request) begin
                    next_state = ST_HALTED;
                    next_cause = CAUSE_EXTERNAL;
                end else if (wd_expire) begin
                    next_state = ST_HALTED;
                    next_cause = CAUSE_WATCHDOG;
                end
            end
            ST_STEP: begin
                next_state = ST_HALTED;
                next_cause = halt_enable ? CAUSE_HALT_INSTR : CAUSE_STEP_DONE;
            end
            ST_HALTED: begin
                if (abort_request) begin
                    next_state = ST_IDLE;
                    next_cause = CAUSE_NONE;
                end else if (cause != CAUSE_HALT_INSTR) begin
                    if (system_start) begin
                        next_state = ST_RUN;
                        enter_exec = 1'b1;
                    end else if (step_request) begin
                        next_state = ST_STEP;
                        enter_exec = 1'b1;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (enter_exec) next_cause = CAUSE_NONE;
    end

    always_comb begin
        system_enabled = ((state == ST_RUN) || (state == ST_STEP)) && !bp_hit;
        system_idle    = (state == ST_IDLE);
        halted         = (state == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            cause        <= CAUSE_NONE;
            bp_hit_index <= '0;
            cycle_count  <= '0;
            wd_count     <= '0;
            skip_bp      <= 1'b0;
        end else if (clk_en) begin
            cause <= next_cause;
            if (latch_bp) bp_hit_index <= raw_idx;
            if (clear_cycles)
                cycle_count <= '0;
            else if (system_enabled && cycle_count != '1)
                cycle_count <= cycle_count + CYCLE_WIDTH'(1);
            // Entry only happens from IDLE/HALTED, where nothing executes.
            if (enter_exec) begin
                wd_count <= '0;
                skip_bp  <= 1'b1;
            end else if (system_enabled) begin
                skip_bp <= 1'b0;
                if (wd_count != '1) wd_count <= wd_count + CYCLE_WIDTH'(1);
            end
        end
    end

    assign halt_cause = cause;

endmodule
